// File: rtl/ahb_lite_gpio_irq_pkg.sv
// Shared register indices and address helper for the AHB-Lite GPIO with interrupts.
package gpio_pkg;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_OE      = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_SET     = 3'd3;
  localparam logic [2:0] GPIO_CLR     = 3'd4;
  localparam logic [2:0] GPIO_RISE_EN = 3'd5;
  localparam logic [2:0] GPIO_FALL_EN = 3'd6;
  localparam logic [2:0] GPIO_STATUS  = 3'd7;

  // Byte-offset bits below the word index for a bus of the given width.
  function automatic int gpio_alsb(input int hdata_width);
    return $clog2(hdata_width / 8);
  endfunction

endpackage

// File: rtl/ahb_lite_gpio_irq_if.sv
// AHB-Lite bus bundle between a master and the GPIO slave.
interface ahb_lite_gpio_irq_if #(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 64
);
  logic [HADDR_WIDTH-1:0] HADDR;
  logic [1:0]             HTRANS;
  logic [2:0]             HSIZE;
  logic                   HWRITE;
  logic [HDATA_WIDTH-1:0] HWDATA;
  logic [HDATA_WIDTH-1:0] HRDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic                   HSEL;
  logic                   HREADYOUT;

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, HSEL,
    input  HRDATA, HRESP, HREADYOUT
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, HSEL,
    output HRDATA, HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_lite_gpio_irq_sync.sv
// Multi-stage flop chain bringing asynchronous pin inputs into the HCLK domain.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [STAGES-1:0][WIDTH-1:0] chain_d;

  // Shift the raw pins one stage deeper every cycle.
  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = d_i;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Chain state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/ahb_lite_gpio_irq.sv
// Zero-wait-state AHB-Lite GPIO slave with atomic set/clear, input
// synchroniser and sticky edge-triggered interrupt status.
module ahb_lite_gpio_irq
  import gpio_pkg::*;
#(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 64,
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_gpio_irq_if.slave    ahb,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int ALSB = gpio_alsb(HDATA_WIDTH);

  logic [HADDR_WIDTH-1:0] haddr_s;
  logic [HDATA_WIDTH-1:0] hwdata_s;
  logic [HDATA_WIDTH-1:0] rdata_s;
  logic                   accept_s;
  logic [GPIO_WIDTH-1:0]  wd_s;
  logic [GPIO_WIDTH-1:0]  sync_s;
  logic [GPIO_WIDTH-1:0]  w1c_s;
  logic [GPIO_WIDTH-1:0]  rise_s;
  logic [GPIO_WIDTH-1:0]  fall_s;
  logic                   unused_s;

  logic                   write_q,   write_d;
  logic [2:0]             idx_q,     idx_d;
  logic [GPIO_WIDTH-1:0]  out_q,     out_d;
  logic [GPIO_WIDTH-1:0]  oe_q,      oe_d;
  logic [GPIO_WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0]  fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0]  status_q,  status_d;
  logic [GPIO_WIDTH-1:0]  prev_q,    prev_d;
  logic                   irq_q,     irq_d;

  assign haddr_s  = ahb.HADDR;
  assign hwdata_s = ahb.HWDATA;
  assign accept_s = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign wd_s     = hwdata_s[GPIO_WIDTH-1:0];
  assign unused_s = ^{ahb.HSIZE, ahb.HTRANS[0], haddr_s, hwdata_s};

  gpio_sync #(
    .WIDTH  (GPIO_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (HCLK),
    .rst (HRESET),
    .d_i (gpio_i),
    .q_o (sync_s)
  );

  // Address-phase capture, data-phase register writes and edge detection.
  always_comb begin
    write_d   = accept_s & ahb.HWRITE;
    idx_d     = accept_s ? haddr_s[ALSB+2:ALSB] : idx_q;
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = '0;
    if (write_q) begin
      case (idx_q)
        GPIO_OUT:     out_d     = wd_s;
        GPIO_OE:      oe_d      = wd_s;
        GPIO_SET:     out_d     = out_q | wd_s;
        GPIO_CLR:     out_d     = out_q & ~wd_s;
        GPIO_RISE_EN: rise_en_d = wd_s;
        GPIO_FALL_EN: fall_en_d = wd_s;
        GPIO_STATUS:  w1c_s     = wd_s;
        default:      w1c_s     = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    prev_d   = sync_s;
    rise_s   = sync_s & ~prev_q & rise_en_q;
    fall_s   = ~sync_s & prev_q & fall_en_q;
    // New edges are ORed in after the clear so they survive a same-cycle W1C.
    status_d = (status_q & ~w1c_s) | rise_s | fall_s;
    irq_d    = |status_d;
  end

  // Read mux driven by the index captured in the address phase.
  always_comb begin
    rdata_s = '0;
    case (idx_q)
      GPIO_OUT:     rdata_s[GPIO_WIDTH-1:0] = out_q;
      GPIO_OE:      rdata_s[GPIO_WIDTH-1:0] = oe_q;
      GPIO_IN:      rdata_s[GPIO_WIDTH-1:0] = sync_s;
      GPIO_RISE_EN: rdata_s[GPIO_WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN: rdata_s[GPIO_WIDTH-1:0] = fall_en_q;
      GPIO_STATUS:  rdata_s[GPIO_WIDTH-1:0] = status_q;
      default:      rdata_s = '0;
    endcase
  end

  // All block state; reset also drops any pending data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      write_q   <= 1'b0;
      idx_q     <= 3'd0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      write_q   <= write_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
    end
  end

  assign ahb.HRDATA    = rdata_s;
  assign ahb.HRESP     = 1'b0;
  assign ahb.HREADYOUT = 1'b1;
  assign gpio_o        = out_q;
  assign gpio_oe       = oe_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_ahb_lite_gpio_irq.sv
// Scoreboard bench: stimulus queues expected values, a monitor pops and compares.
module tb_ahb_lite_gpio_irq;

  localparam int PK_OUT = 0;
  localparam int PK_OE  = 1;
  localparam int PK_IRQ = 2;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } probe_t;

  logic        clk;
  logic        hreset;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe;
  logic        irq;
  logic [63:0] pend_wd;
  logic        rd_dphase;
  int          n_checks;
  int          n_fails;

  logic [63:0] rd_q[$];
  probe_t      probe_q[$];

  ahb_lite_gpio_irq_if #(.HADDR_WIDTH(17), .HDATA_WIDTH(64)) bus_if ();

  ahb_lite_gpio_irq #(
    .HADDR_WIDTH (17),
    .HDATA_WIDTH (64),
    .GPIO_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .HCLK    (clk),
    .HRESET  (hreset),
    .ahb     (bus_if),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: track read data phases from the bus itself.
  always @(posedge clk) begin
    rd_dphase <= !hreset && bus_if.HSEL && bus_if.HTRANS[1] && bus_if.HREADY && !bus_if.HWRITE;
  end

  always @(negedge clk) begin
    if (rd_dphase) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", bus_if.HRDATA, 64'hx);
      end else begin
        check("hrdata", bus_if.HRDATA, rd_q.pop_front());
      end
    end
    while (probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      case (p.kind)
        PK_OUT:  check(p.name, {56'h0, gpio_o}, p.exp);
        PK_OE:   check(p.name, {56'h0, gpio_oe}, p.exp);
        default: check(p.name, {63'h0, irq}, p.exp);
      endcase
    end
  end

  task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] idx, input logic [63:0] wd);
    @(posedge clk); #1;
    bus_if.HWDATA = pend_wd;
    bus_if.HSEL   = sel;
    bus_if.HTRANS = trans;
    bus_if.HWRITE = wr;
    bus_if.HADDR  = {11'h0, idx, 3'b000};
    pend_wd       = wd;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [63:0] d);
    bus(1'b1, 2'b10, 1'b1, idx, d);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [63:0] exp);
    rd_q.push_back(exp);
    bus(1'b1, 2'b10, 1'b0, idx, 64'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 2'b00, 1'b0, 3'd0, 64'h0);
  endtask

  task automatic probe(input int kind, input logic [63:0] exp, input string name);
    probe_t p;
    p.kind = kind;
    p.exp  = exp;
    p.name = name;
    probe_q.push_back(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    pend_wd  = 64'h0;
    gpio_i   = 8'h00;
    hreset   = 1'b1;
    bus_if.HADDR  = 17'h0;
    bus_if.HTRANS = 2'b00;
    bus_if.HSIZE  = 3'b011;
    bus_if.HWRITE = 1'b0;
    bus_if.HWDATA = 64'h0;
    bus_if.HREADY = 1'b1;
    bus_if.HSEL   = 1'b0;
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;

    probe(PK_OUT, 64'h0, "reset_gpio_o");
    probe(PK_OE, 64'h0, "reset_gpio_oe");
    probe(PK_IRQ, 64'h0, "reset_irq");
    for (int i = 0; i < 8; i++) rd(3'(i), 64'h0);
    idle(1);

    // OUT / SET / CLR sequence.
    wr(3'd0, 64'hA5); idle(2); probe(PK_OUT, 64'hA5, "out_write");
    wr(3'd3, 64'h0F); idle(2); probe(PK_OUT, 64'hAF, "out_set");
    wr(3'd4, 64'h81); idle(2); probe(PK_OUT, 64'h2E, "out_clr");
    rd(3'd3, 64'h0); rd(3'd0, 64'h2E); idle(1);
    wr(3'd3, 64'h40); wr(3'd4, 64'h0E); idle(2); probe(PK_OUT, 64'h60, "set_then_clr");

    // Back-to-back write then read of OE.
    wr(3'd1, 64'h3C); rd(3'd1, 64'h3C); idle(1); probe(PK_OE, 64'h3C, "oe_write");

    // Rising-edge latency on pin 0.
    wr(3'd5, 64'h01); idle(2);
    rd(3'd2, 64'h00); gpio_i[0] = 1'b1;
    rd(3'd2, 64'h01); probe(PK_IRQ, 64'h0, "irq_k");
    idle(1); probe(PK_IRQ, 64'h0, "irq_k1");
    idle(1); probe(PK_IRQ, 64'h1, "irq_k2");
    rd(3'd7, 64'h01); wr(3'd7, 64'h01); idle(2); probe(PK_IRQ, 64'h0, "w1c_rise");

    // Falling edge on pin 7 and W1C.
    gpio_i[7] = 1'b1; idle(4); probe(PK_IRQ, 64'h0, "rise7_disabled");
    wr(3'd6, 64'h80); idle(2);
    gpio_i[7] = 1'b0; idle(2); probe(PK_IRQ, 64'h0, "fall_k1");
    idle(1); probe(PK_IRQ, 64'h1, "fall_k2");
    rd(3'd7, 64'h80); wr(3'd7, 64'h80); idle(2); probe(PK_IRQ, 64'h0, "w1c_fall");

    // Edge set beats a same-cycle W1C on bit 0.
    gpio_i[0] = 1'b0; idle(4);
    gpio_i[0] = 1'b1; wr(3'd7, 64'h01); idle(2); probe(PK_IRQ, 64'h1, "set_beats_clr");
    rd(3'd7, 64'h01); wr(3'd7, 64'h01); idle(2); probe(PK_IRQ, 64'h0, "clr_after");

    // Disabled pin never sets status.
    gpio_i[3] = 1'b1; idle(4); probe(PK_IRQ, 64'h0, "disabled_pin"); rd(3'd7, 64'h0); idle(1);

    // IDLE, BUSY and unselected transfers change nothing.
    bus(1'b1, 2'b00, 1'b1, 3'd0, 64'hFF);
    bus(1'b1, 2'b01, 1'b1, 3'd0, 64'hFF);
    bus(1'b0, 2'b10, 1'b1, 3'd0, 64'hFF);
    idle(2); probe(PK_OUT, 64'h60, "idle_no_write"); rd(3'd0, 64'h60); idle(1);

    // Reset during a write data phase discards the write.
    wr(3'd0, 64'h55);
    @(posedge clk); #1;
    bus_if.HWDATA = pend_wd;
    bus_if.HSEL   = 1'b0;
    bus_if.HTRANS = 2'b00;
    pend_wd       = 64'h0;
    hreset        = 1'b1;
    @(posedge clk); #1 hreset = 1'b0;
    probe(PK_OUT, 64'h0, "reset_mid_out");
    probe(PK_OE, 64'h0, "reset_mid_oe");
    probe(PK_IRQ, 64'h0, "reset_mid_irq");
    idle(1); probe(PK_OUT, 64'h0, "reset_mid_out2");
    rd(3'd0, 64'h0); idle(2);

    check("reads_drained", 64'(rd_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
